// File: rtl/rename_freelist.sv
// Physical-register free list for a register-rename stage.
// A circular array of free tags with wrap-bit head/tail pointers.
// Up to WIDTH all-or-nothing allocations and WIDTH retires happen per cycle.
// The head pointer can be checkpointed and restored for branch recovery.
module rename_freelist #(
    parameter int PRF_SIZE  = 64,
    parameter int ARCH_REGS = 32,
    parameter int WIDTH     = 2,
    parameter int NUM_CKPT  = 4,
    localparam int FL_SIZE  = PRF_SIZE - ARCH_REGS,
    localparam int PW       = $clog2(PRF_SIZE),
    localparam int CW       = $clog2(FL_SIZE + 1),
    localparam int KW       = $clog2(NUM_CKPT)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          alloc_req,
    output logic [WIDTH-1:0]          alloc_gnt,
    output logic [WIDTH-1:0][PW-1:0]  alloc_tag,
    input  logic [WIDTH-1:0]          retire_en,
    input  logic [WIDTH-1:0][PW-1:0]  retire_tag,
    input  logic                      ckpt_save,
    input  logic [KW-1:0]             ckpt_id,
    input  logic                      rollback_en,
    input  logic [KW-1:0]             rollback_id,
    output logic [CW-1:0]             free_count,
    output logic                      overflow_err
);

    // Pointer index width plus one wrap bit; equals CW because FL_SIZE is a power of two.
    localparam int IW   = $clog2(FL_SIZE);
    localparam int PTRW = IW + 1;

    logic [PW-1:0]   entry_reg [FL_SIZE];
    logic [PTRW-1:0] ckpt_reg  [NUM_CKPT];
    logic [PTRW-1:0] head_reg, tail_reg;
    logic [PTRW-1:0] head_next, tail_next;
    logic            overflow_reg;

    logic [CW-1:0]            n_req, n_grant, n_ret, room;
    logic                     grant_ok;
    logic [WIDTH-1:0][IW-1:0] alloc_idx, ret_idx;
    logic [WIDTH-1:0]         ret_acc;
    logic                     ret_drop;

    // Empty when pointers match, full when only the wrap bits differ.
    assign free_count   = CW'(tail_reg - head_reg);
    assign overflow_err = overflow_reg;

    // Rank each requesting lane so requests are compacted onto consecutive entries.
    always_comb begin
        n_req     = '0;
        alloc_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            alloc_idx[i] = IW'(head_reg + PTRW'(n_req));
            if (alloc_req[i]) begin
                n_req = n_req + CW'(1);
            end
        end
        grant_ok  = !rollback_en && (n_req <= free_count);
        alloc_gnt = grant_ok ? alloc_req : '0;
        n_grant   = grant_ok ? n_req : '0;
    end

    // Tag mux per lane; reads the pre-edge array, so same-cycle retires never bypass.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        assign alloc_tag[gi] = alloc_gnt[gi] ? entry_reg[alloc_idx[gi]] : '0;
    end

    // Accept retires in ascending lane order until the list would exceed capacity.
    always_comb begin
        room     = CW'(FL_SIZE) - (free_count - n_grant);
        n_ret    = '0;
        ret_acc  = '0;
        ret_drop = 1'b0;
        ret_idx  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ret_idx[i] = IW'(tail_reg + PTRW'(n_ret));
            if (retire_en[i]) begin
                if (n_ret < room) begin
                    ret_acc[i] = 1'b1;
                    n_ret      = n_ret + CW'(1);
                end else begin
                    ret_drop = 1'b1;
                end
            end
        end
        head_next = rollback_en ? ckpt_reg[rollback_id] : head_reg + PTRW'(n_grant);
        tail_next = tail_reg + PTRW'(n_ret);
    end

    // Pointer, checkpoint, array and sticky-error state; reset preloads tags ARCH_REGS upward.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg     <= '0;
            tail_reg     <= PTRW'(FL_SIZE);
            overflow_reg <= 1'b0;
            for (int k = 0; k < NUM_CKPT; k++) begin
                ckpt_reg[k] <= '0;
            end
            for (int i = 0; i < FL_SIZE; i++) begin
                entry_reg[i] <= PW'(ARCH_REGS + i);
            end
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
            if (ret_drop) begin
                overflow_reg <= 1'b1;
            end
            // A rollback in the same cycle suppresses the save.
            if (ckpt_save && !rollback_en) begin
                ckpt_reg[ckpt_id] <= head_next;
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (ret_acc[i]) begin
                    entry_reg[ret_idx[i]] <= retire_tag[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_rename_freelist.sv
// Self-checking bench for rename_freelist: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a model
// that treats the free list as an unbounded, absolutely-indexed log of tags.
module tb_rename_freelist;

    localparam int PRF_SIZE  = 64;
    localparam int ARCH_REGS = 32;
    localparam int WIDTH     = 2;
    localparam int NUM_CKPT  = 4;
    localparam int FL_SIZE   = PRF_SIZE - ARCH_REGS;
    localparam int PW        = $clog2(PRF_SIZE);
    localparam int CW        = $clog2(FL_SIZE + 1);
    localparam int KW        = $clog2(NUM_CKPT);

    logic                     clock = 1'b0;
    logic                     reset;
    logic [WIDTH-1:0]         alloc_req;
    logic [WIDTH-1:0]         alloc_gnt;
    logic [WIDTH-1:0][PW-1:0] alloc_tag;
    logic [WIDTH-1:0]         retire_en;
    logic [WIDTH-1:0][PW-1:0] retire_tag;
    logic                     ckpt_save;
    logic [KW-1:0]            ckpt_id;
    logic                     rollback_en;
    logic [KW-1:0]            rollback_id;
    logic [CW-1:0]            free_count;
    logic                     overflow_err;

    int checks = 0;
    int errors = 0;

    rename_freelist #(
        .PRF_SIZE (PRF_SIZE),
        .ARCH_REGS(ARCH_REGS),
        .WIDTH    (WIDTH),
        .NUM_CKPT (NUM_CKPT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .alloc_req   (alloc_req),
        .alloc_gnt   (alloc_gnt),
        .alloc_tag   (alloc_tag),
        .retire_en   (retire_en),
        .retire_tag  (retire_tag),
        .ckpt_save   (ckpt_save),
        .ckpt_id     (ckpt_id),
        .rollback_en (rollback_en),
        .rollback_id (rollback_id),
        .free_count  (free_count),
        .overflow_err(overflow_err)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    // Free tags live at absolute positions [m_head, m_tail); positions never wrap.
    int m_ent [int];
    int m_head, m_tail;
    int m_ckpt [NUM_CKPT];
    bit m_ovf;
    bit model_valid = 1'b0;

    task automatic model_reset();
        m_ent.delete();
        for (int i = 0; i < FL_SIZE; i++) m_ent[i] = ARCH_REGS + i;
        m_head = 0;
        m_tail = FL_SIZE;
        for (int k = 0; k < NUM_CKPT; k++) m_ckpt[k] = 0;
        m_ovf = 1'b0;
        model_valid = 1'b1;
    endtask

    function automatic int n_alloc_req();
        return $countones(alloc_req);
    endfunction

    function automatic bit model_grants();
        return !rollback_en && (n_alloc_req() <= (m_tail - m_head));
    endfunction

    task automatic model_step();
        int ng, room, acc;
        ng   = model_grants() ? n_alloc_req() : 0;
        room = FL_SIZE - ((m_tail - m_head) - ng);
        acc  = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (retire_en[i]) begin
                if (acc < room) begin
                    m_ent[m_tail + acc] = int'(retire_tag[i]);
                    acc++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        m_tail += acc;
        if (rollback_en) begin
            m_head = m_ckpt[rollback_id];
        end else begin
            m_head += ng;
            if (ckpt_save) m_ckpt[ckpt_id] = m_head;
        end
    endtask

    // Advance the model on every active edge, mirroring the DUT's sampling point.
    always @(posedge clock) begin
        if (reset) model_reset();
        else if (model_valid) model_step();
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model, away from the active edge.
    always @(negedge clock) begin
        if (model_valid) begin
            logic [WIDTH-1:0]         eg;
            logic [WIDTH-1:0][PW-1:0] et;
            int k;
            eg = '0;
            et = '0;
            k  = 0;
            if (model_grants()) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (alloc_req[i]) begin
                        eg[i] = 1'b1;
                        et[i] = PW'(m_ent[m_head + k]);
                        k++;
                    end
                end
            end
            chk("model_gnt", 64'(alloc_gnt), 64'(eg));
            for (int i = 0; i < WIDTH; i++) chk("model_tag", 64'(alloc_tag[i]), 64'(et[i]));
            chk("model_free_count", 64'(free_count), 64'(m_tail - m_head));
            chk("model_overflow", 64'(overflow_err), 64'(m_ovf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_idle();
        alloc_req   = '0;
        retire_en   = '0;
        retire_tag  = '0;
        ckpt_save   = 1'b0;
        ckpt_id     = '0;
        rollback_en = 1'b0;
        rollback_id = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // A rollback is legal only if the restored window still lies inside the live array.
    function automatic bit rollback_ok(input int id);
        return (m_ckpt[id] <= m_head) && (m_tail - m_ckpt[id] + WIDTH <= FL_SIZE);
    endfunction

    initial begin
        drive_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state, then two-lane allocation.
        #1;
        chk("reset_free_count", 64'(free_count), 64'd32);
        chk("reset_overflow", 64'(overflow_err), 64'd0);
        chk("reset_idle_gnt", 64'(alloc_gnt), 64'd0);
        alloc_req = 2'b11;
        #1;
        chk("dual_gnt", 64'(alloc_gnt), 64'd3);
        chk("dual_tag0", 64'(alloc_tag[0]), 64'd32);
        chk("dual_tag1", 64'(alloc_tag[1]), 64'd33);
        tick();
        drive_idle();
        chk("dual_free_after", 64'(free_count), 64'd30);
        $display("txn dual_alloc: free_count=%0d", free_count);

        // Compaction: a lone lane-1 request takes the head entry.
        do_reset();
        alloc_req = 2'b10;
        #1;
        chk("lane1_gnt", 64'(alloc_gnt), 64'd2);
        chk("lane1_tag1", 64'(alloc_tag[1]), 64'd32);
        chk("lane1_tag0_zero", 64'(alloc_tag[0]), 64'd0);
        tick();
        alloc_req = 2'b01;
        #1;
        chk("lane0_tag0", 64'(alloc_tag[0]), 64'd33);
        tick();
        drive_idle();
        $display("txn compaction: free_count=%0d", free_count);

        // All-or-nothing near empty.
        do_reset();
        alloc_req = 2'b11;
        for (int c = 0; c < 15; c++) tick();
        alloc_req = 2'b01;
        tick();
        drive_idle();
        chk("drain_free_one", 64'(free_count), 64'd1);
        alloc_req = 2'b11;
        #1;
        chk("short_gnt_none", 64'(alloc_gnt), 64'd0);
        tick();
        chk("short_free_kept", 64'(free_count), 64'd1);
        alloc_req = 2'b01;
        #1;
        chk("last_gnt", 64'(alloc_gnt), 64'd1);
        chk("last_tag", 64'(alloc_tag[0]), 64'd63);
        tick();
        drive_idle();
        chk("empty_free", 64'(free_count), 64'd0);
        $display("txn drain: free_count=%0d", free_count);

        // Checkpoint then rollback.
        do_reset();
        alloc_req = 2'b11;
        ckpt_save = 1'b1;
        ckpt_id   = 2'd2;
        tick();
        ckpt_save = 1'b0;
        tick();
        tick();
        rollback_en = 1'b1;
        rollback_id = 2'd2;
        #1;
        chk("rollback_gnt_forced", 64'(alloc_gnt), 64'd0);
        tick();
        rollback_en = 1'b0;
        #1;
        chk("rollback_tag0", 64'(alloc_tag[0]), 64'd34);
        chk("rollback_tag1", 64'(alloc_tag[1]), 64'd35);
        tick();
        drive_idle();
        chk("rollback_free", 64'(free_count), 64'd28);
        $display("txn rollback: free_count=%0d", free_count);

        // Overflow from full is dropped and sticky.
        do_reset();
        retire_en     = 2'b01;
        retire_tag[0] = PW'(5);
        tick();
        drive_idle();
        chk("ovf_free_full", 64'(free_count), 64'd32);
        chk("ovf_set", 64'(overflow_err), 64'd1);
        tick();
        tick();
        chk("ovf_sticky", 64'(overflow_err), 64'd1);
        do_reset();
        chk("ovf_cleared", 64'(overflow_err), 64'd0);
        $display("txn overflow: overflow_err=%0d", overflow_err);

        // Steady alloc/retire across the pointer wrap.
        for (int c = 0; c < 40; c++) begin
            alloc_req     = 2'b01;
            retire_en     = 2'b01;
            retire_tag[0] = PW'(c + 1);
            #1;
            chk("wrap_tag", 64'(alloc_tag[0]), (c < 32) ? 64'(32 + c) : 64'(c - 31));
            tick();
            chk("wrap_free", 64'(free_count), 64'd32);
        end
        drive_idle();
        $display("txn wrap: free_count=%0d", free_count);

        // Randomized traffic; the negedge compare checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            int rid;
            alloc_req = WIDTH'($urandom_range(0, 3));
            retire_en = WIDTH'($urandom_range(0, 3));
            for (int i = 0; i < WIDTH; i++) retire_tag[i] = PW'($urandom_range(0, PRF_SIZE - 1));
            ckpt_save   = ($urandom_range(0, 7) == 0);
            ckpt_id     = KW'($urandom_range(0, NUM_CKPT - 1));
            rid         = $urandom_range(0, NUM_CKPT - 1);
            rollback_id = KW'(rid);
            rollback_en = ($urandom_range(0, 9) == 0) && rollback_ok(rid);
            reset       = ($urandom_range(0, 499) == 0);
            tick();
            if (c % 500 == 0)
                $display("txn random %0d: free_count=%0d overflow_err=%0d", c, free_count, overflow_err);
        end
        reset = 1'b0;
        drive_idle();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
